// File: rtl/cpu_seq_ctrl_if.sv
// rtl/cpu_seq_ctrl_if.sv - instruction fetch and register-file port bundle for cpu_seq_ctrl
interface cpu_seq_ctrl_if;
    logic        imem_req;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [4:0]  rf_rs1;
    logic [4:0]  rf_rs2;
    logic [31:0] rf_rd1;
    logic [31:0] rf_rd2;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wd;
    logic        rf_we;

    modport master (
        output imem_req, rf_rs1, rf_rs2, rf_rd, rf_wd, rf_we,
        input  imem_ready, imem_rdata, rf_rd1, rf_rd2
    );

    modport slave (
        input  imem_req, rf_rs1, rf_rs2, rf_rd, rf_wd, rf_we,
        output imem_ready, imem_rdata, rf_rd1, rf_rd2
    );
endinterface

// File: rtl/cpu_seq_ctrl.sv
// rtl/cpu_seq_ctrl.sv - multi-cycle RV32I sequencer executing ADDI/ADD, halting on anything else
module cpu_seq_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic                 step,
    cpu_seq_ctrl_if.master       bus,
    output logic [31:0]          pc,
    output logic [31:0]          ir,
    output logic                 busy,
    output logic                 halted,
    output logic [31:0]          retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] result;

    logic is_addi;
    logic is_add;
    logic legal;

    assign is_addi = (ir[6:0] == 7'b0010011) && (ir[14:12] == 3'b000);
    assign is_add  = (ir[6:0] == 7'b0110011) && (ir[14:12] == 3'b000) &&
                     (ir[31:25] == 7'b0000000);
    assign legal   = is_addi || is_add;

    assign bus.rf_rs1 = ir[19:15];
    assign bus.rf_rs2 = ir[24:20];
    assign bus.rf_rd  = ir[11:7];
    assign bus.rf_wd  = result;

    // Write enable is gated by reset so a reset landing in WB abandons the write.
    assign bus.rf_we    = (state == S_WB) && (ir[11:7] != 5'd0) && reset;
    assign bus.imem_req = (state == S_FETCH);
    assign busy         = (state == S_FETCH) || (state == S_DECODE) ||
                          (state == S_EXEC)  || (state == S_WB);
    assign halted       = (state == S_HALT);

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (run || step) state_next = S_FETCH;
            S_FETCH:  if (bus.imem_ready) state_next = S_DECODE;
            S_DECODE: state_next = legal ? S_EXEC : S_HALT;
            S_EXEC:   state_next = S_WB;
            S_WB:     state_next = run ? S_FETCH : S_IDLE;
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= S_IDLE;
            pc      <= RESET_PC;
            ir      <= 32'd0;
            op_a    <= 32'd0;
            op_b    <= 32'd0;
            result  <= 32'd0;
            retired <= 32'd0;
        end else begin
            state <= state_next;
            case (state)
                S_FETCH: if (bus.imem_ready) ir <= bus.imem_rdata;
                S_DECODE: if (legal) begin
                    op_a <= bus.rf_rd1;
                    op_b <= is_add ? bus.rf_rd2 : {{20{ir[31]}}, ir[31:20]};
                end
                S_EXEC: result <= op_a + op_b;
                S_WB: begin
                    pc      <= pc + 32'd4;
                    retired <= retired + 32'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
